// File: rtl/clock_divider_bank_pkg.sv
// Shared constants and helpers for the clock divider bank.
// No ports; imported by the interface, the channel and the top level.
package clk_gen_pkg;

    localparam int MAX_CH    = 16;
    localparam int DEF_DIV_W = 4;

    // Start-phase preload limited to the last count of a half period.
    // A stopped channel (div of 0) always starts from count 0.
    function automatic int clamp_phase(input int phase, input int div);
        if (div == 0) begin
            return 0;
        end
        if (phase > div - 1) begin
            return div - 1;
        end
        return phase;
    endfunction

endpackage

// File: rtl/clock_divider_bank_if.sv
// Runtime divide-ratio config port (valid/ready handshake).
// Ports: cfg_valid, cfg_ch, cfg_div from master; cfg_ready from slave.
interface clock_divider_bank_if #(
    parameter int DIV_W = 4
);
    logic             cfg_valid;
    logic [3:0]       cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_div,
        output cfg_ready
    );
endinterface

// File: rtl/clock_divider_bank_channel.sv
// One divider channel: half-period counter, level, tick, shadow divide.
// Ports: clock, reset, start, run, wr, wr_div in; clk_out, tick, pending out.
module clock_divider_channel
    import clk_gen_pkg::*;
#(
    parameter int               DIV_W      = DEF_DIV_W,
    parameter logic [DIV_W-1:0] DIV_INIT   = 1,
    parameter logic [DIV_W-1:0] PHASE_INIT = '0,
    parameter logic             INV        = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             run,
    input  logic             wr,
    input  logic [DIV_W-1:0] wr_div,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic             level_q, level_d;
    logic             pend_q, pend_d;
    logic             wrap;

    assign wrap    = (cnt_q == div_q - 1'b1);
    assign pending = pend_q;

    always_comb begin
        div_d    = div_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        level_d  = level_q;
        pend_d   = pend_q;
        if (start) begin
            cnt_d   = DIV_W'(clamp_phase(int'(PHASE_INIT), int'(div_q)));
            level_d = 1'b0;
        end else if (run) begin
            if (div_q == '0) begin
                // Stopped: a pending ratio applies on the very next edge.
                cnt_d   = '0;
                level_d = 1'b0;
                if (pend_q) begin
                    div_d  = shadow_q;
                    pend_d = 1'b0;
                end
            end else if (wrap) begin
                cnt_d   = '0;
                level_d = ~level_q;
                // Only a falling edge may swap the ratio (glitch-free).
                if (level_q && pend_q) begin
                    div_d  = shadow_q;
                    pend_d = 1'b0;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // wr is only possible while pend_q is low, so no apply clash.
            if (wr) begin
                shadow_d = wr_div;
                pend_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q    <= DIV_INIT;
            cnt_q    <= '0;
            shadow_q <= '0;
            level_q  <= 1'b0;
            pend_q   <= 1'b0;
            clk_out  <= INV;
            tick     <= 1'b0;
        end else begin
            div_q    <= div_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            level_q  <= level_d;
            pend_q   <= pend_d;
            clk_out  <= level_d ^ INV;
            tick     <= level_d & ~level_q;
        end
    end

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel clock divider bank with runtime ratio reconfiguration.
// Ports: clock, reset, cfg (config slave); clk_out, tick, ready out.
module clock_divider_bank
    import clk_gen_pkg::*;
#(
    parameter int                      NUM_CH      = 4,
    parameter int                      DIV_W       = DEF_DIV_W,
    parameter logic [NUM_CH*DIV_W-1:0] DIV_INIT    = {4'd2, 4'd2, 4'd1, 4'd1},
    parameter logic [NUM_CH*DIV_W-1:0] PHASE_INIT  = '0,
    parameter logic [NUM_CH-1:0]       INV_INIT    = 4'b0010,
    parameter int                      START_DELAY = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    clock_divider_bank_if.slave  cfg,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick,
    output logic                 ready
);

    localparam int SW = $clog2(START_DELAY + 1);

    logic [SW-1:0]     scnt_q;
    logic              ready_q;
    logic              start;
    logic              xfer;
    logic              sel_pend;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] wr;

    // start is the single edge S on which all channels load their phase.
    assign start = !ready_q && (scnt_q == SW'(START_DELAY - 1));
    assign ready = ready_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scnt_q  <= '0;
            ready_q <= 1'b0;
        end else if (!ready_q) begin
            scnt_q <= scnt_q + 1'b1;
            if (start) begin
                ready_q <= 1'b1;
            end
        end
    end

    // Out-of-range channel indices match nothing: accepted, discarded.
    always_comb begin
        sel_pend = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(cfg.cfg_ch) == i) begin
                sel_pend = pend[i];
            end
        end
    end

    assign cfg.cfg_ready = ready_q && !sel_pend;
    assign xfer          = cfg.cfg_valid && cfg.cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign wr[g] = xfer && (int'(cfg.cfg_ch) == g);

        clock_divider_channel #(
            .DIV_W      (DIV_W),
            .DIV_INIT   (DIV_INIT[g*DIV_W +: DIV_W]),
            .PHASE_INIT (PHASE_INIT[g*DIV_W +: DIV_W]),
            .INV        (INV_INIT[g])
        ) u_ch (
            .clock   (clock),
            .reset   (reset),
            .start   (start),
            .run     (ready_q),
            .wr      (wr[g]),
            .wr_div  (cfg.cfg_div),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pending (pend[g])
        );
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Self-checking bench for clock_divider_bank against a countdown model.
// Drives the config interface and compares outputs every master cycle.
module tb_clock_divider_bank;

    localparam int NCH = 4;
    localparam int DW  = 4;
    localparam int SD  = 2;
    localparam logic [NCH*DW-1:0] DINIT = {4'd2, 4'd2, 4'd1, 4'd1};
    localparam logic [NCH*DW-1:0] PINIT = {4'd7, 4'd1, 4'd0, 4'd0};
    localparam logic [NCH-1:0]    IINIT = 4'b0010;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic           ready;

    clock_divider_bank_if #(.DIV_W(DW)) cfg_bus ();

    clock_divider_bank #(
        .NUM_CH      (NCH),
        .DIV_W       (DW),
        .DIV_INIT    (DINIT),
        .PHASE_INIT  (PINIT),
        .INV_INIT    (IINIT),
        .START_DELAY (SD)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .cfg     (cfg_bus),
        .clk_out (clk_out),
        .tick    (tick),
        .ready   (ready)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: per channel, edges remaining until the next level toggle.
    bit m_ready;
    int m_scnt;
    bit m_lvl  [NCH];
    bit m_tk   [NCH];
    bit m_pend [NCH];
    int m_div  [NCH];
    int m_sh   [NCH];
    int m_rem  [NCH];

    logic           obs_cr;
    logic           exp_cr;
    logic [2*NCH:0] e_all;

    task automatic model_reset();
        m_ready = 1'b0;
        m_scnt  = 0;
        for (int i = 0; i < NCH; i++) begin
            m_lvl[i]  = 1'b0;
            m_tk[i]   = 1'b0;
            m_pend[i] = 1'b0;
            m_div[i]  = int'(DINIT[i*DW +: DW]);
            m_sh[i]   = 0;
            m_rem[i]  = 0;
        end
    endtask

    task automatic model_edge(input bit xfer, input int ch, input int dv);
        int ph;
        if (!m_ready) begin
            m_scnt++;
            if (m_scnt == SD) begin
                m_ready = 1'b1;
                for (int i = 0; i < NCH; i++) begin
                    ph = int'(PINIT[i*DW +: DW]);
                    if (m_div[i] == 0) m_rem[i] = 0;
                    else m_rem[i] = m_div[i] - ((ph < m_div[i]) ? ph : m_div[i] - 1);
                end
            end
            return;
        end
        for (int i = 0; i < NCH; i++) begin
            m_tk[i] = 1'b0;
            if (m_div[i] == 0) begin
                if (m_pend[i]) begin
                    m_div[i]  = m_sh[i];
                    m_pend[i] = 1'b0;
                    m_rem[i]  = m_div[i];
                end
            end else begin
                m_rem[i]--;
                if (m_rem[i] == 0) begin
                    if (m_lvl[i]) begin
                        m_lvl[i] = 1'b0;
                        if (m_pend[i]) begin
                            m_div[i]  = m_sh[i];
                            m_pend[i] = 1'b0;
                        end
                    end else begin
                        m_lvl[i] = 1'b1;
                        m_tk[i]  = 1'b1;
                    end
                    m_rem[i] = m_div[i];
                end
            end
        end
        if (xfer && ch < NCH) begin
            m_sh[ch]   = dv;
            m_pend[ch] = 1'b1;
        end
    endtask

    // Drive one cycle of config input, advance the model, build expectations.
    task automatic cycle(input bit v, input int ch, input int dv);
        bit xf;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_ch    = 4'(ch);
        cfg_bus.cfg_div   = DW'(dv);
        #1;
        obs_cr = cfg_bus.cfg_ready;
        exp_cr = m_ready && (ch >= NCH || !m_pend[ch]);
        xf     = v && exp_cr;
        @(posedge clock);
        model_edge(xf, ch, dv);
        #1;
        e_all[2*NCH] = m_ready;
        for (int i = 0; i < NCH; i++) begin
            e_all[NCH+i] = m_tk[i];
            e_all[i]     = m_lvl[i] ^ IINIT[i];
        end
    endtask

    task automatic test_reset();
        reset             = 1'b0;
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = 4'd0;
        cfg_bus.cfg_div   = 4'd3;
        model_reset();
        @(posedge clock);
        @(posedge clock);
        #1;
        n_cmp++;
        if ({ready, tick, clk_out} !== {1'b0, 4'b0000, IINIT}) begin
            n_bad++;
            $display("FAIL reset outputs: got %b want %b", {ready, tick, clk_out}, {1'b0, 4'b0000, IINIT});
        end
        n_cmp++;
        if (cfg_bus.cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset cfg_ready: got %b want 0", cfg_bus.cfg_ready);
        end
        cfg_bus.cfg_valid = 1'b0;
        reset = 1'b1;
    endtask

    task automatic test_start();
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 0, 0);
            n_cmp++;
            if (obs_cr !== exp_cr) begin
                n_bad++;
                $display("FAIL start cfg_ready: got %b want %b k=%0d", obs_cr, exp_cr, k);
            end
            n_cmp++;
            if ({ready, tick, clk_out} !== e_all) begin
                n_bad++;
                $display("FAIL start outputs: got %b want %b k=%0d", {ready, tick, clk_out}, e_all, k);
            end
            n_cmp++;
            if (ready !== (k >= SD)) begin
                n_bad++;
                $display("FAIL start ready: got %b want %b k=%0d", ready, (k >= SD), k);
            end
            if (k == SD + 1) begin
                n_cmp++;
                if ({tick[0], clk_out[1], clk_out[2], clk_out[3]} !== 4'b1011) begin
                    n_bad++;
                    $display("FAIL start first edge: got %b want 1011",
                             {tick[0], clk_out[1], clk_out[2], clk_out[3]});
                end
            end
        end
    endtask

    task automatic test_reconfig();
        for (int k = 0; k < 10 && !m_lvl[0]; k++) begin
            cycle(1'b0, 0, 0);
            n_cmp++;
            if ({ready, tick, clk_out} !== e_all) begin
                n_bad++;
                $display("FAIL reconfig align: got %b want %b", {ready, tick, clk_out}, e_all);
            end
        end
        for (int k = 0; k < 24; k++) begin
            cycle(k < 8, 0, 3);
            n_cmp++;
            if (obs_cr !== exp_cr) begin
                n_bad++;
                $display("FAIL reconfig cfg_ready: got %b want %b k=%0d", obs_cr, exp_cr, k);
            end
            n_cmp++;
            if ({ready, tick, clk_out} !== e_all) begin
                n_bad++;
                $display("FAIL reconfig outputs: got %b want %b k=%0d", {ready, tick, clk_out}, e_all, k);
            end
            if (k == 1) begin
                n_cmp++;
                if (obs_cr !== 1'b0) begin
                    n_bad++;
                    $display("FAIL reconfig stall: got %b want 0", obs_cr);
                end
            end
        end
    endtask

    task automatic test_stop_restart();
        for (int k = 0; k < 30; k++) begin
            if (k == 0) cycle(1'b1, 3, 0);
            else if (k == 16) cycle(1'b1, 3, 1);
            else cycle(1'b0, 0, 0);
            n_cmp++;
            if (obs_cr !== exp_cr) begin
                n_bad++;
                $display("FAIL stop cfg_ready: got %b want %b k=%0d", obs_cr, exp_cr, k);
            end
            n_cmp++;
            if ({ready, tick, clk_out} !== e_all) begin
                n_bad++;
                $display("FAIL stop outputs: got %b want %b k=%0d", {ready, tick, clk_out}, e_all, k);
            end
            if (k >= 8 && k <= 15) begin
                n_cmp++;
                if ({clk_out[3], tick[3]} !== 2'b00) begin
                    n_bad++;
                    $display("FAIL stop held low: got %b want 00 k=%0d", {clk_out[3], tick[3]}, k);
                end
            end
        end
    endtask

    task automatic test_out_of_range();
        for (int k = 0; k < 6; k++) begin
            cycle(k == 0, 9, 5);
            n_cmp++;
            if (k == 0 && obs_cr !== 1'b1) begin
                n_bad++;
                $display("FAIL oor cfg_ready: got %b want 1", obs_cr);
            end
            n_cmp++;
            if ({ready, tick, clk_out} !== e_all) begin
                n_bad++;
                $display("FAIL oor outputs: got %b want %b k=%0d", {ready, tick, clk_out}, e_all, k);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 600; k++) begin
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
                  int'($urandom_range(0, 4)));
            n_cmp++;
            if (obs_cr !== exp_cr) begin
                n_bad++;
                $display("FAIL random cfg_ready: got %b want %b k=%0d", obs_cr, exp_cr, k);
            end
            n_cmp++;
            if ({ready, tick, clk_out} !== e_all) begin
                n_bad++;
                $display("FAIL random outputs: got %b want %b k=%0d", {ready, tick, clk_out}, e_all, k);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 20 && !m_pend[2]; k++) begin
            cycle(1'b1, 2, 5);
        end
        cfg_bus.cfg_valid = 1'b0;
        n_cmp++;
        if (!m_pend[2]) begin
            n_bad++;
            $display("FAIL midreset setup: pending got 0 want 1");
        end
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({ready, tick, clk_out} !== {1'b0, 4'b0000, IINIT}) begin
            n_bad++;
            $display("FAIL midreset outputs: got %b want %b", {ready, tick, clk_out}, {1'b0, 4'b0000, IINIT});
        end
        n_cmp++;
        if (cfg_bus.cfg_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL midreset cfg_ready: got %b want 0", cfg_bus.cfg_ready);
        end
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b0, 0, 0);
            n_cmp++;
            if ({ready, tick, clk_out} !== e_all) begin
                n_bad++;
                $display("FAIL restart outputs: got %b want %b k=%0d", {ready, tick, clk_out}, e_all, k);
            end
            if (k == SD + 1 || k == SD + 3) begin
                n_cmp++;
                if (clk_out[2] !== (k == SD + 1)) begin
                    n_bad++;
                    $display("FAIL restart ch2 level: got %b want %b k=%0d", clk_out[2], (k == SD + 1), k);
                end
            end
        end
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = 4'd0;
        cfg_bus.cfg_div   = 4'd0;
        test_reset();
        test_start();
        test_reconfig();
        test_stop_restart();
        test_out_of_range();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
Parametrised multi-channel clock-divider bank that generates the divided clock phases used by the processor, instruction memory, data memory and register file from one master clock.
- Each channel has its own divide ratio, start phase and output polarity, all set at elaboration.
- Divide ratios can be changed at runtime through a valid/ready config port. Changes take effect only at a low-going boundary, so outputs never glitch.
- Sits at the top level, between the board clock and the core's clock consumers.

Parameters:
NUM_CH, 4, number of output channels (1..16)
DIV_W, 4, width of per-channel half-period divide value
DIV_INIT, {4'd2,4'd2,4'd1,4'd1}, packed NUM_CH*DIV_W reset-time divide value per channel (ch0 in LSBs)
PHASE_INIT, all zeros, packed NUM_CH*DIV_W start-phase counter preload per channel
INV_INIT, 4'b0010, per-channel output inversion (ch1 = inverted, e.g. dmem)
START_DELAY, 2, master-clock cycles after reset release before channels start (>=1)

Ports:
clock  input  1  master clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
cfg_valid  input  1  config request
cfg_ch  input  4  target channel index
cfg_div  input  DIV_W  new half-period divide value; 0 = stop channel
cfg_ready  output  1  config accepted this cycle when high with cfg_valid
clk_out  output  NUM_CH  divided clocks, registered
tick  output  NUM_CH  one-cycle pulse on the cycle each clk_out channel rises (pre-inversion level)
ready  output  1  high once channels have started

Behaviour:
- Reset low, asynchronous: level[i]=0, clk_out[i]=INV_INIT[i], tick=0, ready=0, start counter=0, pending=0, div[i]=DIV_INIT[i].
- Start sequence:
  - After reset rises, the start counter counts posedges.
  - On posedge START_DELAY (edge S): ready<=1, and every channel loads cnt[i]<=min(PHASE_INIT[i], div[i]-1), level[i]<=0.
  - All channels start on the same edge.
- Running channel with div>0, each posedge after S:
  - if cnt==div-1: level toggles and cnt<=0;
  - else cnt<=cnt+1.
  - Period = 2*div master cycles, duty 50%.
- clk_out[i] = level[i] XOR INV_INIT[i], registered.
- tick[i] = 1 exactly in the cycle level[i] first reads 1.
- div==0: level held 0, cnt held 0, no ticks.
- Config handshake:
  - cfg_ready = ready AND NOT pending[cfg_ch]; for cfg_ch>=NUM_CH, cfg_ready = ready.
  - Transfer on cfg_valid&&cfg_ready: shadow[cfg_ch]<=cfg_div, pending[cfg_ch]<=1.
  - Out-of-range cfg_ch: accepted and discarded, no state change.
- Config apply:
  - Pending shadow applies on the edge where level goes 1->0: div<=shadow, cnt<=0, pending<=0.
  - If the channel is stopped (div==0), it applies on the next edge instead: cnt<=0, level stays 0, so the first rise comes new_div edges later.
  - Applying 0 stops the channel low after its falling edge.
  - Phase is not reapplied on reconfig.
- Before ready, cfg_ready=0 and no transfer occurs.
- Simultaneous transfer and apply on the same channel is impossible: pending blocks the transfer.
- Reset mid-operation: all state is cleared immediately, outputs return to reset values, and in-flight config is lost.

Decomposition:
- Package clk_gen_pkg: MAX_CH=16, DIV_W default, function clamp_phase(phase, div).
- One sub-module, clock_divider_channel: counter, level, tick, shadow/pending and apply logic for a single channel. The top level instantiates NUM_CH of them in a generate loop and adds the start counter and config decode.

Test Plan:
- Defaults, reset released at t0, START_DELAY=2 -> ready rises at edge S=2. ch0 rises at S+1 and falls at S+2 (period 2). ch2 rises at S+2 (period 4). ch1 idles at 1 and drops at S+1. tick[0] is high at S+1, S+3, ...
- PHASE_INIT ch2=1, div=2 -> ch2 rises at S+1, one cycle earlier than ch3, then period 4; PHASE_INIT=7 with div=2 is clamped to 1.
- After ready, write ch0 cfg_div=3 while ch0 is high -> cfg_ready for ch0 drops next cycle. New div applies at ch0's next falling edge, then high 3 / low 3. A repeat write is stalled until apply.
- Write ch3 cfg_div=0, then later cfg_div=1 -> ch3 stops low after its falling edge and stays low. It restarts with its first rise 1 edge after apply, with no runt pulse.
- cfg_ch=9 with NUM_CH=4, cfg_valid=1 -> cfg_ready=1 and all channels are unchanged.
- Drive reset low mid-period with a pending config -> outputs go to reset values asynchronously. After release, channels restart with DIV_INIT, not the pending value.
